// File: rtl/toysram_wb_pkg.sv
// Shared types and constants for the Wishbone command bridge toward toysram.
// Command FIFO entries pack {we, sel, adr, dat} with dat in the low bits.
package toysram_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  localparam int DAT_W   = 32;
  localparam int SEL_W   = 4;
  localparam int DAT_LSB = 0;
  localparam int ADR_LSB = DAT_W;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_DEAD;

  function automatic int sel_lsb(input int adr_w);
    return ADR_LSB + adr_w;
  endfunction

  function automatic int we_bit(input int adr_w);
    return ADR_LSB + adr_w + SEL_W;
  endfunction

  function automatic int entry_w(input int adr_w);
    return 1 + SEL_W + adr_w + DAT_W;
  endfunction

endpackage

// File: rtl/wb_cmd_bridge_cmd_fifo.sv
// Synchronous FIFO (module cmd_fifo) holding queued Wishbone commands.
// The head entry is read straight from storage so it stays stable until popped.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_cmd_bridge.sv
// Wishbone single-beat slave that queues window hits as commands toward toysram.
// Optional macro WB_SLAVE_ERR_EN adds wbs_err_o for read timeouts and sel==0 requests.
module wb_cmd_bridge
  import toysram_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] BASE_MASK    = 32'hF000_0000,
  parameter int          ADR_W        = 28,
  parameter int          CMD_DEPTH    = 4,
  parameter int          RD_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
`ifdef WB_SLAVE_ERR_EN
  output logic             wbs_err_o,
`endif
  output logic [31:0]      wbs_dat_o,
  output logic             cmd_val,
  input  logic             cmd_rdy,
  output logic [ADR_W-1:0] cmd_adr,
  output logic             cmd_we,
  output logic [3:0]       cmd_sel,
  output logic [31:0]      cmd_dat,
  input  logic             rd_ack,
  input  logic [31:0]      rd_dat,
  output logic             fifo_full
);

  localparam int          ENTRY_W = entry_w(ADR_W);
  localparam int          SEL_LSB = sel_lsb(ADR_W);
  localparam int          WE_BIT  = we_bit(ADR_W);
  localparam logic [15:0] TO_LAST = 16'(RD_TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        cnt_q;
  logic               abort_q;
  logic               req;
  logic               sel_bad;
  logic               accept;
  logic               rd_timeout;
  logic               abort_now;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;

  assign req = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & BASE_MASK) == BASE_ADDR);
`ifdef WB_SLAVE_ERR_EN
  logic rsp_err_q;
  assign sel_bad = (wbs_sel_i == 4'b0000);
`else
  assign sel_bad = 1'b0;
`endif
  assign accept     = (state == ST_IDLE) & req & ~sel_bad & ~fifo_full;
  assign rd_timeout = (cnt_q == TO_LAST);
  assign abort_now  = abort_q | ~wbs_cyc_i;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req & sel_bad)  state_nxt = ST_ACK;
        else if (accept)    state_nxt = wbs_we_i ? ST_ACK : ST_RD_WAIT;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      ST_RD_WAIT: begin
        if (rd_ack | rd_timeout) state_nxt = abort_now ? ST_IDLE : ST_ACK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read tracking: wait counter, abort flag and returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      wbs_dat_o <= '0;
`ifdef WB_SLAVE_ERR_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept & ~wbs_we_i) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
          end
`ifdef WB_SLAVE_ERR_EN
          rsp_err_q <= req & sel_bad;
`endif
        end
        ST_RD_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          if (~wbs_cyc_i) abort_q <= 1'b1;
          if (rd_ack & ~abort_now)           wbs_dat_o <= rd_dat;
          else if (rd_timeout & ~abort_now)  wbs_dat_o <= TIMEOUT_DATA;
`ifdef WB_SLAVE_ERR_EN
          rsp_err_q <= ~rd_ack & rd_timeout;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
`ifdef WB_SLAVE_ERR_EN
    wbs_ack_o = (state == ST_ACK) & ~rsp_err_q;
    wbs_err_o = (state == ST_ACK) &  rsp_err_q;
`else
    wbs_ack_o = (state == ST_ACK);
`endif
  end

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({wbs_we_i, wbs_sel_i, wbs_adr_i[ADR_W-1:0], wbs_dat_i}),
    .pop   (cmd_val & cmd_rdy),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_val = ~fifo_empty;
  assign cmd_dat = head[DAT_LSB +: DAT_W];
  assign cmd_adr = head[ADR_LSB +: ADR_W];
  assign cmd_sel = head[SEL_LSB +: SEL_W];
  assign cmd_we  = head[WE_BIT];

endmodule

// File: tb/tb_wb_cmd_bridge.sv
// Self-checking bench for wb_cmd_bridge with a command scoreboard (RD_TIMEOUT=8).
// Builds with or without WB_SLAVE_ERR_EN.
module tb_wb_cmd_bridge;

  logic        clk;
  logic        rst;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic        resp_err;
  logic [31:0] wbs_dat_o;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [27:0] cmd_adr;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rd_ack;
  logic [31:0] rd_dat;
  logic        fifo_full;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [27:0] adr;
    logic [31:0] dat;
  } cmd_t;

  cmd_t sb[$];
  int   total = 0;
  int   bad   = 0;

  wb_cmd_bridge #(.RD_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
`ifdef WB_SLAVE_ERR_EN
    .wbs_err_o (resp_err),
`endif
    .wbs_dat_o (wbs_dat_o),
    .cmd_val   (cmd_val),
    .cmd_rdy   (cmd_rdy),
    .cmd_adr   (cmd_adr),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_dat   (cmd_dat),
    .rd_ack    (rd_ack),
    .rd_dat    (rd_dat),
    .fifo_full (fifo_full)
  );

`ifndef WB_SLAVE_ERR_EN
  assign resp_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit track);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    if (track) sb.push_back(cmd_t'{we, sel, adr[27:0], dat});
  endtask

  // Step until ack or err is seen; an exhausted budget is a failed comparison.
  task automatic wait_resp(input string tag, input int budget, output int cycles, output logic got_err);
    bit seen;
    seen    = 1'b0;
    cycles  = 0;
    got_err = 1'b0;
    while (!seen && cycles < budget) begin
      step();
      cycles++;
      if (wbs_ack_o || resp_err) begin
        seen    = 1'b1;
        got_err = resp_err;
      end
    end
    if (!seen) check({tag, "_no_resp"}, 32'd0, 32'd1);
  endtask

  task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit track, output int cycles);
    logic e;
    drive(1'b1, adr, dat, sel, track);
    wait_resp(tag, 20, cycles, e);
    drop();
  endtask

  // Command monitor: compare every popped head against the scoreboard.
  always begin
    @(posedge clk);
    #3;
    if (!rst && cmd_val && cmd_rdy) begin
      if (sb.size() > 0) begin
        cmd_t e;
        e = sb.pop_front();
        check("cmd_we",  {31'd0, cmd_we},  {31'd0, e.we});
        check("cmd_sel", {28'd0, cmd_sel}, {28'd0, e.sel});
        check("cmd_adr", {4'd0, cmd_adr},  {4'd0, e.adr});
        check("cmd_dat", cmd_dat, e.dat);
      end else begin
        check("cmd_unexpected_pop", 32'(sb.size()), 32'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    int   acks;
    int   vals;
    logic e;

    rst = 1'b1;
    cmd_rdy = 1'b1;
    rd_ack = 1'b0;
    rd_dat = '0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    wbs_sel_i = '0;
    drop();
    repeat (3) step();
    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_val", {31'd0, cmd_val}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    rst = 1'b0;
    step();

    // Single posted write.
    wb_write("wr1", 32'h3000_0010, 32'hA5A5_A5A5, 4'hF, 1'b1, cyc);
    check("wr1_latency", cyc, 32'd1);
    step();
    check("wr1_ack_one_cycle", {31'd0, wbs_ack_o}, 32'd0);
    step();

    // Read answered three cycles after cmd_val.
    drive(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b1);
    step();
    drop();
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    check("rd1_cmd_val", {31'd0, cmd_val}, 32'd1);
    acks = 0;
    repeat (3) begin
      step();
      acks += int'(wbs_ack_o);
    end
    check("rd1_no_early_ack", acks, 32'd0);
    rd_ack = 1'b1;
    rd_dat = 32'h1234_5678;
    step();
    rd_ack = 1'b0;
    check("rd1_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("rd1_dat", wbs_dat_o, 32'h1234_5678);
    drop();
    step();
    check("rd1_ack_drop", {31'd0, wbs_ack_o}, 32'd0);

    // Back-pressure: four writes fill the FIFO, the fifth stalls.
    cmd_rdy = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      wb_write("bp_wr", 32'h3000_0100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 1'b1, cyc);
      acks += int'(cyc == 1);
      step();
    end
    check("bp_four_acks", acks, 32'd4);
    check("bp_full", {31'd0, fifo_full}, 32'd1);
    drive(1'b1, 32'h3000_0110, 32'h1000_0004, 4'h3, 1'b1);
    acks = 0;
    repeat (5) begin
      step();
      acks += int'(wbs_ack_o);
    end
    check("bp_stall_no_ack", acks, 32'd0);
    cmd_rdy = 1'b1;
    wait_resp("bp_wr5", 6, cyc, e);
    check("bp_wr5_ack", {31'd0, wbs_ack_o}, 32'd1);
    drop();
    cyc = 0;
    while (cmd_val && cyc < 20) begin
      step();
      cyc++;
    end
    check("bp_drained", {31'd0, cmd_val}, 32'd0);

    // Read timeout after 8 RD_WAIT cycles.
    drive(1'b0, 32'h3000_0200, 32'h0, 4'hF, 1'b1);
    wait_resp("to_rd", 20, cyc, e);
    check("to_latency", cyc, 32'd9);
    check("to_dat", wbs_dat_o, 32'hDEAD_DEAD);
`ifdef WB_SLAVE_ERR_EN
    check("to_err", {31'd0, e}, 32'd1);
`else
    check("to_err", {31'd0, e}, 32'd0);
`endif
    drop();
    step();

    // Outside the window: ignored.
    drive(1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b0);
    acks = 0;
    vals = 0;
    repeat (4) begin
      step();
      acks += int'(wbs_ack_o | resp_err);
      vals += int'(cmd_val);
    end
    check("oow_no_ack", acks, 32'd0);
    check("oow_no_push", vals, 32'd0);
    drop();
    step();

    // Abort: cyc drops in RD_WAIT, late rd_ack gives no ack and keeps wbs_dat_o.
    drive(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1'b1);
    step();
    drop();
    repeat (2) step();
    rd_ack = 1'b1;
    rd_dat = 32'h5555_5555;
    step();
    rd_ack = 1'b0;
    acks = int'(wbs_ack_o | resp_err);
    repeat (2) begin
      step();
      acks += int'(wbs_ack_o | resp_err);
    end
    check("abort_no_ack", acks, 32'd0);
    check("abort_dat_kept", wbs_dat_o, 32'hDEAD_DEAD);
    wb_write("post_abort_wr", 32'h3000_0040, 32'hCAFE_F00D, 4'hC, 1'b1, cyc);
    check("post_abort_latency", cyc, 32'd1);
    step();

    // sel == 0 handling depends on the optional error response.
`ifdef WB_SLAVE_ERR_EN
    drive(1'b1, 32'h3000_0050, 32'h7777_7777, 4'h0, 1'b0);
    wait_resp("sel0", 5, cyc, e);
    check("sel0_err", {31'd0, e}, 32'd1);
    check("sel0_latency", cyc, 32'd1);
`else
    drive(1'b1, 32'h3000_0050, 32'h7777_7777, 4'h0, 1'b1);
    wait_resp("sel0", 5, cyc, e);
    check("sel0_ack", {31'd0, wbs_ack_o}, 32'd1);
    check("sel0_latency", cyc, 32'd1);
`endif
    drop();
    repeat (3) step();

    // Reset with three queued writes and a pending read.
    cmd_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_write("rst_wr", 32'h3000_0300 + 32'(i * 4), 32'(i), 4'hF, 1'b0, cyc);
      step();
    end
    drive(1'b0, 32'h3000_0400, 32'h0, 4'hF, 1'b0);
    step();
    rst = 1'b1;
    drop();
    step();
    check("mid_rst_val", {31'd0, cmd_val}, 32'd0);
    check("mid_rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("mid_rst_full", {31'd0, fifo_full}, 32'd0);
    rst = 1'b0;
    rd_ack = 1'b1;
    rd_dat = 32'h9999_9999;
    step();
    rd_ack = 1'b0;
    cmd_rdy = 1'b1;
    acks = 0;
    repeat (3) begin
      step();
      acks += int'(wbs_ack_o | resp_err);
    end
    check("rst_late_rd_ack_ignored", acks, 32'd0);
    check("rst_dat_cleared", wbs_dat_o, 32'd0);
    check("rst_flushed", {31'd0, cmd_val}, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_cmd_bridge.md
Name: wb_cmd_bridge

Overview:
Parametrised successor to the single-register Wishbone slave bridge. It accepts classic Wishbone single-beat transfers inside a configurable address window and queues them in a command FIFO toward the internal SRAM/site logic using a valid/ready handshake. Writes are posted and acked when they are enqueued. Reads are tracked until rd_ack arrives or a timeout expires. Sits between the Caravel wishbone port and the toysram command decode.

Parameters:
BASE_ADDR, 'h30000000, window base; a request matches when (wbs_adr_i & BASE_MASK) == BASE_ADDR
BASE_MASK, 'hF0000000, window mask
ADR_W, 28, width of cmd_adr; carries wbs_adr_i[ADR_W-1:0]
CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2
RD_TIMEOUT, 255, cycles waited for rd_ack before a forced completion; range 1..65535
TIMEOUT_DATA, 'hDEADDEAD, wbs_dat_o value returned on a read timeout

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
wbs_stb_i  in  1  WB strobe
wbs_cyc_i  in  1  WB cycle
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte selects
wbs_dat_i  in  32  WB write data
wbs_adr_i  in  32  WB address
wbs_ack_o  out  1  WB acknowledge, registered
wbs_dat_o  out  32  WB read data, registered
cmd_val  out  1  FIFO head valid
cmd_rdy  in  1  downstream accepts the head
cmd_adr  out  ADR_W  head address
cmd_we  out  1  head write flag
cmd_sel  out  4  head byte selects
cmd_dat  out  32  head write data
rd_ack  in  1  read data valid, one-cycle pulse
rd_dat  in  32  read data
fifo_full  out  1  status: FIFO full

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE and the FIFO is flushed. On the next cycle wbs_ack_o=0, wbs_dat_o=0, cmd_val=0, fifo_full=0, and the timeout counter is 0.
- Reset mid-operation drops all queued commands and any pending read. No ack is issued.
- Request seen = wbs_cyc_i & wbs_stb_i & match, sampled only in IDLE. Non-matching requests are ignored; no ack is issued.
- FSM states: IDLE, ACK, RD_WAIT.
- IDLE, request with FIFO full: stall. Nothing is pushed and the bridge stays in IDLE. The master holds stb until the FIFO frees.
- IDLE, write request, FIFO not full: push {we, sel, adr, dat} and go to ACK.
- IDLE, read request, FIFO not full: push the entry, clear the counter, clear the abort flag, and go to RD_WAIT.
- ACK: wbs_ack_o=1 for exactly one cycle, then return to IDLE.
- Write latency: request sampled at edge T, so wbs_ack_o is high in cycle T+1. cmd_val is high no later than T+1.
- RD_WAIT: the counter increments each cycle.
  - rd_ack=1: capture rd_dat into wbs_dat_o and go to ACK, so the ack appears one cycle after rd_ack.
  - Counter reaches RD_TIMEOUT with no rd_ack: load TIMEOUT_DATA and go to ACK.
  - rd_ack in the same cycle as the timeout: rd_ack wins.
- Abort: wbs_cyc_i=0 in any RD_WAIT cycle sets the abort flag. On resolution (rd_ack or timeout) the FSM goes to IDLE with no ack, and wbs_dat_o is left unchanged.
- rd_ack outside RD_WAIT is ignored.
- FIFO:
  - Push occurs on the IDLE acceptance cycle. Pop occurs when cmd_val & cmd_rdy.
  - Simultaneous push and pop when full is not allowed; the push is stalled. Simultaneous push and pop at any other level leaves the level unchanged.
  - Pointers are log2(CMD_DEPTH) bits and wrap naturally. The count is log2(CMD_DEPTH)+1 bits.
  - Ordering is strict FIFO, so a read completes only after all earlier writes have drained.
- cmd_* outputs come directly from the FIFO head storage. They must be stable while cmd_val & ~cmd_rdy.

Optional Feature:
Macro WB_SLAVE_ERR_EN.
- Defined: adds port wbs_err_o (out, 1). A read timeout asserts wbs_err_o for one cycle in place of wbs_ack_o, and wbs_dat_o is loaded with TIMEOUT_DATA. A request that matches the window with wbs_sel_i==4'b0000 is not enqueued and gets wbs_err_o the next cycle. wbs_err_o resets to 0.
- Not defined: no port. A timeout acks with TIMEOUT_DATA, and a sel==0 request is handled like any other request.

Decomposition:
- Package toysram_wb_pkg holds:
  - FSM state encoding (2 bits)
  - FIFO entry field offsets, with entry width 1+4+ADR_W+32
  - Default TIMEOUT_DATA constant
- Sub-module cmd_fifo (parameters WIDTH, DEPTH): a synchronous FIFO with push/pop/full/empty, instantiated once.

Test Plan:
- Single write to 'h30000010, data 'hA5A5A5A5, sel 'hF, cmd_rdy=1 -> ack one cycle after the request is sampled; cmd_adr='h0000010, cmd_we=1, cmd_dat='hA5A5A5A5 on one cmd_val cycle.
- Read of 'h30000020, rd_ack with rd_dat 'h12345678 three cycles after cmd_val -> wbs_ack_o one cycle after rd_ack, wbs_dat_o='h12345678.
- cmd_rdy=0 with 5 back-to-back writes, CMD_DEPTH=4 -> 4 acks, fifo_full=1, 5th write stalled with no ack. Raising cmd_rdy -> 5th write acked, and cmd_adr order matches issue order.
- Read with no rd_ack, RD_TIMEOUT=8 -> ack after 8 RD_WAIT cycles with wbs_dat_o='hDEADDEAD (wbs_err_o instead of ack when WB_SLAVE_ERR_EN).
- Read to 'h40000000 (outside window) -> no push and no ack. Read with cyc dropped in RD_WAIT, then rd_ack -> no ack, FSM back to IDLE, next write acked normally.
- rst asserted with 3 queued entries and a pending read -> cmd_val=0 and wbs_ack_o=0 the next cycle; a later rd_ack is ignored.
